// File: rtl/print_arbiter.sv
// Shares the PRINT transmit unit among N requesters using req/ack handshakes.
// Define PRINT_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module print_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  // Per-requester type (0 = raw byte, 1 = hex word); "type" is a reserved word.
  input  logic [N-1:0]    req_type,
  input  logic [32*N-1:0] dout,
  output logic [N-1:0]    ack,
  output logic            req_tx,
  output logic            type_tx,
  output logic [31:0]     dout_tx,
  input  logic            ack_tx,
  output logic            busy,
  output logic [IW-1:0]   gnt_id
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  localparam logic [N-1:0] ACK_ONE = N'(1);

  state_t        state_reg;
  logic [31:0]   dout_arr [N];
  logic [IW-1:0] win;
  logic [IW-1:0] idx;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign dout_arr[gi] = dout[32*gi +: 32];
    end
  endgenerate

`ifdef PRINT_ARB_RR_EN
  logic [IW-1:0] ptr_reg;

  // Walk the candidates from farthest to nearest so the nearest one after ptr wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_reg) + 1 + k) % N);
      if (req[idx]) begin
        win = idx;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'(k);
      if (req[idx]) begin
        win = idx;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      req_tx    <= 1'b0;
      type_tx   <= 1'b0;
      dout_tx   <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      gnt_id    <= '0;
`ifdef PRINT_ARB_RR_EN
      ptr_reg   <= IW'(N - 1);
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            dout_tx   <= dout_arr[win];
            type_tx   <= req_type[win];
            gnt_id    <= win;
            req_tx    <= 1'b1;
            busy      <= 1'b1;
            state_reg <= ST_BUSY;
`ifdef PRINT_ARB_RR_EN
            ptr_reg   <= win;
`endif
          end
        end
        ST_BUSY: begin
          // req_tx drops with the ack so PRINT never sees a second request.
          if (ack_tx) begin
            req_tx    <= 1'b0;
            ack       <= ACK_ONE << gnt_id;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack       <= '0;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_print_arbiter.sv
// Self-checking bench for print_arbiter: the bench plays both the requesters and PRINT.
module tb_print_arbiter;
  localparam int N = 4;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N-1:0]    req_type;
  logic [32*N-1:0] dout;
  logic [N-1:0]    ack;
  logic            req_tx;
  logic            type_tx;
  logic [31:0]     dout_tx;
  logic            ack_tx;
  logic            busy;
  logic [1:0]      gnt_id;

  logic [31:0] d [N];

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        typ;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ord[5];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign dout[32*gi +: 32] = d[gi];
  end

  print_arbiter #(.N(N)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_type (req_type),
    .dout     (dout),
    .ack      (ack),
    .req_tx   (req_tx),
    .type_tx  (type_tx),
    .dout_tx  (dout_tx),
    .ack_tx   (ack_tx),
    .busy     (busy),
    .gnt_id   (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) check("ack_onehot", 64'($onehot0(ack)), 64'd1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Characters PRINT would emit for the latched request.
  function automatic logic [63:0] fmt(input logic [31:0] v, input logic t);
    logic [63:0] r;
    logic [3:0]  nib;
    r = '0;
    if (!t) begin
      r[7:0] = v[7:0];
    end else begin
      for (int i = 0; i < 8; i++) begin
        nib = v[31-4*i -: 4];
        r[63-8*i -: 8] = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end
    end
    return r;
  endfunction

  task automatic push_exp(input int id);
    txn_t e;
    e.id   = id;
    e.data = d[id];
    e.typ  = req_type[id];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    req    = '0;
    ack_tx = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_tx", 64'(req_tx), 64'd0);
    check("rst_type_tx", 64'(type_tx), 64'd0);
    check("rst_dout_tx", 64'(dout_tx), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt_id", 64'(gnt_id), 64'd0);
    rstn = 1'b1;
    tick();
  endtask

  // Wait for a grant, hold off ack_tx for 'hold' cycles, then complete the print.
  task automatic serve_one(input int hold);
    txn_t e;
    int   cyc;
    cyc = 0;
    while (!req_tx && cyc < 20) begin
      tick();
      cyc++;
    end
    check("grant_in_time", 64'(cyc < 20), 64'd1);
    if (sb.size() == 0) begin
      check("sb_has_entry", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    $display("txn id=%0d type=%0d data=%08h gnt_id=%0d dout_tx=%08h", e.id, e.typ, e.data, gnt_id, dout_tx);
    check("gnt_id", 64'(gnt_id), 64'(e.id));
    check("dout_tx", 64'(dout_tx), 64'(e.data));
    check("type_tx", 64'(type_tx), 64'(e.typ));
    check("busy_grant", 64'(busy), 64'd1);
    repeat (hold) begin
      tick();
      check("hold_req_tx", 64'(req_tx), 64'd1);
      check("hold_dout_tx", 64'(dout_tx), 64'(e.data));
      check("hold_type_tx", 64'(type_tx), 64'(e.typ));
      check("hold_ack", 64'(ack), 64'd0);
    end
    ack_tx = 1'b1;
    tick();
    ack_tx = 1'b0;
    check("req_tx_fall", 64'(req_tx), 64'd0);
    check("ack_pulse", 64'(ack), 64'd1 << e.id);
    check("busy_done", 64'(busy), 64'd1);
    req[e.id] = 1'b0;
    tick();
    check("ack_clear", 64'(ack), 64'd0);
    check("busy_fall", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    req      = '0;
    req_type = '0;
    ack_tx   = 1'b0;
    for (int i = 0; i < N; i++) d[i] = '0;
    do_reset();

    // ack_tx while idle must be ignored
    ack_tx = 1'b1;
    tick();
    ack_tx = 1'b0;
    check("idle_ack_tx_req_tx", 64'(req_tx), 64'd0);
    check("idle_ack_tx_ack", 64'(ack), 64'd0);
    check("idle_ack_tx_busy", 64'(busy), 64'd0);

    // single byte from requester 1
    d[1] = 32'h0000_0041;
    req_type[1] = 1'b0;
    push_exp(1);
    req[1] = 1'b1;
    tick();
    check("latency_req_tx", 64'(req_tx), 64'd1);
    check("byte_chars", fmt(dout_tx, type_tx), 64'h41);
    serve_one(2);

    // hex word from requester 0
    d[0] = 32'hDEAD_BEEF;
    req_type[0] = 1'b1;
    push_exp(0);
    req[0] = 1'b1;
    tick();
    check("word_chars", fmt(dout_tx, type_tx), "DEADBEEF");
    serve_one(3);
    repeat (3) begin
      tick();
      check("word_single_txn", 64'(req_tx), 64'd0);
    end

    // contention from reset; requester 0 re-asserts after its first ack
    do_reset();
    for (int i = 0; i < N; i++) begin
      d[i] = 32'hA000_0000 + i;
      req_type[i] = i[0];
    end
`ifdef PRINT_ARB_RR_EN
    ord = '{0, 1, 2, 3, 0};
`else
    ord = '{0, 0, 1, 2, 3};
`endif
    for (int i = 0; i < 5; i++) push_exp(ord[i]);
    req = 4'b1111;
    serve_one(1);
    req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("back_to_back", 64'(req_tx), 64'd1);
      serve_one(1);
    end

    // pointer wrap
    do_reset();
    for (int i = 0; i < N; i++) begin
      d[i] = 32'hB000_0000 + i;
      req_type[i] = 1'b0;
    end
    req = 4'b1000;
    push_exp(3);
    serve_one(1);
    req = 4'b1001;
    push_exp(0);
    serve_one(1);
    req[0] = 1'b1;
`ifdef PRINT_ARB_RR_EN
    push_exp(3);
    push_exp(0);
`else
    push_exp(0);
    push_exp(3);
`endif
    serve_one(1);
    serve_one(1);

    // request data changes and withdrawal while busy
    do_reset();
    d[2] = 32'hCAFE_0002;
    req_type[2] = 1'b0;
    push_exp(2);
    req[2] = 1'b1;
    tick();
    check("stab_req_tx", 64'(req_tx), 64'd1);
    d[2] = 32'h1234_5678;
    req_type[2] = 1'b1;
    req[2] = 1'b0;
    serve_one(3);
    repeat (2) begin
      tick();
      check("stab_no_regrant", 64'(req_tx), 64'd0);
    end

    // reset in the middle of a word print
    d[0] = 32'h0BAD_F00D;
    req_type[0] = 1'b1;
    req[0] = 1'b1;
    tick();
    check("rst_mid_pre_req_tx", 64'(req_tx), 64'd1);
    tick();
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_req_tx", 64'(req_tx), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ack", 64'(ack), 64'd0);
    check("rst_mid_dout_tx", 64'(dout_tx), 64'd0);
    req[0] = 1'b0;
    repeat (2) begin
      tick();
      check("rst_hold_ack", 64'(ack), 64'd0);
      check("rst_hold_req_tx", 64'(req_tx), 64'd0);
    end
    rstn = 1'b1;
    tick();
    d[1] = 32'h0000_0031;
    req_type[1] = 1'b0;
    push_exp(1);
    req[1] = 1'b1;
    serve_one(2);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
